branch_resolve_unit: RTL and testbench

EX-stage counterpart to the BTB: carries each fetched instruction's BTB prediction (hit, predicted PC) down the IF→ID→EX pipeline and compares it with the branch outcome resolved in EX. From that comparison it drives the BTB update port, the PC redirect, and the front-end flush. It also keeps branch and misprediction statistics for the performance readout.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/pred_stage_reg.sv | 30 +++
 rtl/branch_resolve_unit.sv | 132 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit.
// pred_t is one prediction slot as it travels IF->ID->EX:
//   valid : slot holds a live fetched instruction
//   pc    : fetch PC of that instruction
//   hit   : BTB hit seen at fetch
//   ppc   : BTB predicted target seen at fetch
package branch_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] ppc;
  } pred_t;

  localparam pred_t PRED_EMPTY = '{valid: 1'b0, pc: 32'd0, hit: 1'b0, ppc: 32'd0};

endpackage

// File: rtl/pred_stage_reg.sv
// One pipeline slot of BTB prediction state.
// Ports:
//   clk   : system clock
//   clear : empty the slot (wins over load)
//   load  : capture d
//   d     : incoming prediction record
//   q     : held prediction record
// With neither clear nor load the slot holds its contents.
module pred_stage_reg
  import branch_pkg::*;
(
  input  logic  clk,
  input  logic  clear,
  input  logic  load,
  input  pred_t d,
  output pred_t q
);

  // Slot register: clear beats load, otherwise hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= PRED_EMPTY;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver paired with the BTB. Carries each fetched
// instruction's prediction through D and E slots, compares it with the
// branch outcome in EX, and drives BTB update, PC redirect and front-end
// flush. Keeps saturating branch / misprediction counters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   CurrentPC, BTBhit, PrePC : IF-stage PC and its BTB lookup result
//   StallF/D/E, FlushD/E     : hazard-unit slot controls
//   IsBranchE, BranchE, BrNPC: EX branch flag, taken flag, taken target
//   UpdEn, UpdPC, UpdTarget  : BTB write port (combinational)
//   Redirect, RedirectPC     : mispredict and the correct next PC
//   FlushFE                  : kill IF/ID and ID/EX (same as Redirect)
//   BranchCnt, MissCnt       : resolved branch / mispredict counts
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      CurrentPC,
  input  logic             BTBhit,
  input  logic [31:0]      PrePC,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             StallE,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             IsBranchE,
  input  logic             BranchE,
  input  logic [31:0]      BrNPC,
  output logic             UpdEn,
  output logic [31:0]      UpdPC,
  output logic [31:0]      UpdTarget,
  output logic             Redirect,
  output logic [31:0]      RedirectPC,
  output logic             FlushFE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MissCnt
);

  pred_t d_next, d_slot, e_next, e_slot;
  logic  clear_d, clear_e;
  logic  resolve_act, alias_act;
  logic  [31:0] fall_pc;

  // Slot inputs: a stalled F feeds a bubble into D, a stalled D feeds a bubble into E.
  always_comb begin
    d_next       = '{valid: ~StallF, pc: CurrentPC, hit: BTBhit, ppc: PrePC};
    e_next       = d_slot;
    e_next.valid = d_slot.valid & ~StallD;
    clear_d      = rst | Redirect | FlushD;
    clear_e      = rst | Redirect | FlushE;
  end

  pred_stage_reg u_slot_d (
    .clk   (clk),
    .clear (clear_d),
    .load  (~StallD),
    .d     (d_next),
    .q     (d_slot)
  );

  pred_stage_reg u_slot_e (
    .clk   (clk),
    .clear (clear_e),
    .load  (~StallE),
    .d     (e_next),
    .q     (e_slot)
  );

  // Resolution compare: outcome of the E-slot instruction against its prediction.
  always_comb begin
    UpdEn       = 1'b0;
    UpdPC       = 32'd0;
    UpdTarget   = 32'd0;
    Redirect    = 1'b0;
    RedirectPC  = 32'd0;
    fall_pc     = e_slot.pc + PC_INC;
    resolve_act = e_slot.valid & IsBranchE & ~StallE;
    // A BTB hit on something that is not a branch steered fetch wrongly;
    // recover to the fall-through PC but never count or write it.
    alias_act   = e_slot.valid & ~IsBranchE & e_slot.hit & ~StallE;
    if (resolve_act) begin
      if (BranchE) begin
        if (!e_slot.hit || (e_slot.ppc != BrNPC)) begin
          Redirect   = 1'b1;
          RedirectPC = BrNPC;
          UpdEn      = 1'b1;
          UpdPC      = e_slot.pc;
          UpdTarget  = BrNPC;
        end else begin
          Redirect   = 1'b0;
        end
      end else if (e_slot.hit) begin
        Redirect   = 1'b1;
        RedirectPC = fall_pc;
      end else begin
        Redirect   = 1'b0;
      end
    end else if (alias_act) begin
      Redirect   = 1'b1;
      RedirectPC = fall_pc;
    end else begin
      Redirect   = 1'b0;
    end
    FlushFE = Redirect;
  end

  // Statistics: count each resolved branch and each mispredict, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCnt <= {CNT_W{1'b0}};
      MissCnt   <= {CNT_W{1'b0}};
    end else if (resolve_act) begin
      if (BranchCnt != {CNT_W{1'b1}}) begin
        BranchCnt <= BranchCnt + CNT_W'(1);
      end else begin
        BranchCnt <= BranchCnt;
      end
      if (Redirect && (MissCnt != {CNT_W{1'b1}})) begin
        MissCnt <= MissCnt + CNT_W'(1);
      end else begin
        MissCnt <= MissCnt;
      end
    end else begin
      BranchCnt <= BranchCnt;
      MissCnt   <= MissCnt;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (narrow counters so saturation is reached).
module tb_branch_resolve_unit;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   CurrentPC = 32'd0, PrePC = 32'd0, BrNPC = 32'd0;
  logic          BTBhit = 1'b0;
  logic          StallF = 1'b0, StallD = 1'b0, StallE = 1'b0;
  logic          FlushD = 1'b0, FlushE = 1'b0;
  logic          IsBranchE = 1'b0, BranchE = 1'b0;
  logic          UpdEn, Redirect, FlushFE;
  logic [31:0]   UpdPC, UpdTarget, RedirectPC;
  logic [CW-1:0] BranchCnt, MissCnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .CurrentPC(CurrentPC), .BTBhit(BTBhit), .PrePC(PrePC),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .IsBranchE(IsBranchE), .BranchE(BranchE), .BrNPC(BrNPC),
    .UpdEn(UpdEn), .UpdPC(UpdPC), .UpdTarget(UpdTarget),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .FlushFE(FlushFE),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  typedef struct packed {
    logic        r, sf, sd, se, fd, fe, isb, br, hit;
    logic [31:0] cpc, ppc, npc;
  } stim_t;

  typedef struct {
    logic        red;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] upc;
    logic [31:0] utg;
    int          bc;
    int          mc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: what each in-flight instruction carries, plus counts.
  logic        md_v = 1'b0, md_h = 1'b0, me_v = 1'b0, me_h = 1'b0;
  logic [31:0] md_pc = 32'd0, md_pp = 32'd0, me_pc = 32'd0, me_pp = 32'd0;
  int          m_bc = 0, m_mc = 0;

  // Expected outputs for the current cycle from the resolution rules.
  function automatic exp_t predict();
    exp_t x;
    x.red = 1'b0; x.rpc = 32'd0; x.upd = 1'b0; x.upc = 32'd0; x.utg = 32'd0;
    x.bc = m_bc; x.mc = m_mc;
    if (me_v && !StallE) begin
      if (IsBranchE && BranchE) begin
        // taken: wrong unless the BTB predicted exactly this target
        if (!me_h || me_pp != BrNPC) begin
          x.red = 1'b1; x.rpc = BrNPC; x.upd = 1'b1; x.upc = me_pc; x.utg = BrNPC;
        end
      end else if (me_h) begin
        // not taken (or not a branch) but fetch followed a BTB hit
        x.red = 1'b1; x.rpc = me_pc + 32'd4;
      end
    end
    return x;
  endfunction

  // Advance the model across one clock edge using the inputs of the ending cycle.
  task automatic model_edge(input logic red);
    if (rst) begin
      md_v = 1'b0; me_v = 1'b0; m_bc = 0; m_mc = 0;
    end else begin
      if (me_v && IsBranchE && !StallE) begin
        if (m_bc < SAT) m_bc++;
        if (red && m_mc < SAT) m_mc++;
      end
      if (red) begin
        md_v = 1'b0; me_v = 1'b0;
      end else begin
        if (FlushE) me_v = 1'b0;
        else if (!StallE) begin
          me_v = md_v && !StallD; me_pc = md_pc; me_h = md_h; me_pp = md_pp;
        end
        if (FlushD) md_v = 1'b0;
        else if (!StallD) begin
          md_v = !StallF; md_pc = CurrentPC; md_h = BTBhit; md_pp = PrePC;
        end
      end
    end
  endtask

  task automatic step(input stim_t s);
    exp_t cur;
    @(posedge clk);
    cur = predict();
    model_edge(cur.red);
    #1;
    rst = s.r; StallF = s.sf; StallD = s.sd; StallE = s.se;
    FlushD = s.fd; FlushE = s.fe; IsBranchE = s.isb; BranchE = s.br;
    CurrentPC = s.cpc; BTBhit = s.hit; PrePC = s.ppc; BrNPC = s.npc;
    sb_q.push_back(predict());
  endtask

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endfunction

  // Monitor: pop one expected record per cycle and compare mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("Redirect",   32'(Redirect),   32'(x.red));
      check("FlushFE",    32'(FlushFE),    32'(x.red));
      check("RedirectPC", RedirectPC,      x.rpc);
      check("UpdEn",      32'(UpdEn),      32'(x.upd));
      check("UpdPC",      UpdPC,           x.upc);
      check("UpdTarget",  UpdTarget,       x.utg);
      check("BranchCnt",  32'(BranchCnt),  32'(x.bc));
      check("MissCnt",    32'(MissCnt),    32'(x.mc));
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Put pc/hit/ppc into fetch, a filler cycle, then resolve it with the given outcome.
  task automatic run_branch(input logic [31:0] pc, input logic hit, input logic [31:0] ppc,
                            input logic br, input logic [31:0] npc);
    stim_t s;
    s = idle(); s.cpc = pc; s.hit = hit; s.ppc = ppc; step(s);
    s = idle(); s.cpc = pc + 32'd4; step(s);
    s = idle(); s.cpc = pc + 32'd8; s.isb = 1'b1; s.br = br; s.npc = npc; step(s);
  endtask

  initial begin
    stim_t s;
    int    waited;
    // reset state
    s = idle(); s.r = 1'b1; step(s); step(s);
    // cold miss taken, correct predict, not-taken with hit, wrong target
    run_branch(32'h100, 1'b0, 32'h0,   1'b1, 32'h140);
    run_branch(32'h140, 1'b1, 32'h140, 1'b1, 32'h140);
    run_branch(32'h200, 1'b1, 32'h240, 1'b0, 32'h0);
    // slots must be empty now: a taken branch here must not resolve
    s = idle(); s.isb = 1'b1; s.br = 1'b1; s.npc = 32'h999; step(s);
    run_branch(32'h2f0, 1'b1, 32'h300, 1'b1, 32'h380);
    // mispredicting branch in E held by StallE for 3 cycles
    s = idle(); s.cpc = 32'h400; s.hit = 1'b1; s.ppc = 32'h300; step(s);
    s = idle(); s.cpc = 32'h404; step(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.sf = 1'b1; s.sd = 1'b1; s.se = 1'b1; s.isb = 1'b1; s.br = 1'b1;
      s.npc = 32'h380; step(s);
    end
    s = idle(); s.isb = 1'b1; s.br = 1'b1; s.npc = 32'h380; step(s);
    step(idle());
    // drive misses until both counters saturate
    for (int i = 0; i < 70; i++) begin
      s = idle(); s.cpc = 32'(i) << 2; s.isb = 1'b1; s.br = 1'b1; s.npc = 32'h500; step(s);
    end
    // reset mid-stream
    s = idle(); s.cpc = 32'h600; s.isb = 1'b1; s.br = 1'b1; s.npc = 32'h700; s.r = 1'b1; step(s);
    s = idle(); s.isb = 1'b1; s.br = 1'b1; s.npc = 32'h700; step(s);
    // randomized run
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.r   = ($urandom_range(0, 299) == 0);
      s.sf  = ($urandom_range(0, 5) == 0);
      s.sd  = ($urandom_range(0, 5) == 0);
      s.se  = ($urandom_range(0, 5) == 0);
      s.fd  = ($urandom_range(0, 9) == 0);
      s.fe  = ($urandom_range(0, 9) == 0);
      s.isb = $urandom_range(0, 1) == 1;
      s.br  = $urandom_range(0, 1) == 1;
      s.hit = $urandom_range(0, 1) == 1;
      s.cpc = 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 2))
        0:       s.ppc = 32'h140;
        1:       s.ppc = s.cpc + 32'd4;
        default: s.ppc = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       s.npc = 32'h140;
        1:       s.npc = 32'h380;
        default: s.npc = $urandom;
      endcase
      step(s);
    end
    step(idle());
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
